access_control: RTL and testbench
=================================

# access_control

Login stage for the game. It sits between the button decoder and the process controller. It consumes shaped single-cycle button pulses from the decoder's access-control output and a digit from the toggle switches. It collects a user ID and a 4-digit password, checks them against per-user passwords set by parameter, and reports grant or deny. After repeated failures it locks out input for a fixed time.

## Interface
- PASSWORDS, 64'h0000_1111_2222_3333, four 16-bit passwords (4 hex digits each); user 0 in [63:48], user 3 in [15:0]; first-entered digit is the most significant nibble.
- MAX_TRIES, 3, consecutive failed checks that trigger lockout (1..7).
- LOCK_CYCLES, 250_000_000, lockout duration in clk cycles (5 s at 50 MHz); 32-bit.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ButtonVector  input  3  shaped one-cycle pulses: [0] enter, [1] clear, [2] logout.
- Entry  input  4  digit value, taken from ToggleSwitch[3:0] at the top level.
- LoggedIn  output  1  high while a user is logged in.
- UserId  output  2  latched user ID; valid while LoggedIn.
- Failed  output  1  one-cycle pulse on every failed password check.
- Locked  output  1  high during lockout.
- DigitCount  output  3  number of password digits entered so far (0..4), for display.
- Phase  output  3  state code: IDLE=0, PWD=1, CHECK=2, GRANTED=3, LOCKED=4.

## Operation
- Button priority when pulses coincide: logout > clear > enter. Only the highest-priority pulse acts.
- IDLE
  - enter with Entry <= 3: latch Entry[1:0] as the user, clear the digit register and count, go to PWD.
  - enter with Entry > 3: ignored.
  - clear and logout: no effect.
- PWD
  - enter: shift Entry into a 16-bit register ({reg[11:0], Entry}) and increment DigitCount.
  - On the 4th digit, go to CHECK.
  - clear: DigitCount=0, register cleared, stay in PWD with the same user.
  - logout: abandon entry and go to IDLE; the fail counter is unchanged.
- CHECK (exactly one cycle, buttons ignored)
  - Compare the register with the selected user's 16-bit slice of PASSWORDS.
  - Match: fail counter cleared, go to GRANTED.
  - Mismatch: Failed pulses for one cycle and the fail counter increments.
    - If the new count equals MAX_TRIES: load the lock timer with LOCK_CYCLES-1 and go to LOCKED.
    - Otherwise go to IDLE.
- GRANTED
  - LoggedIn=1.
  - logout: go to IDLE, LoggedIn drops.
  - enter and clear: ignored.
- LOCKED
  - All buttons ignored. The timer decrements each cycle.
  - When the timer is 0: go to IDLE and clear the fail counter.
  - Total time spent in LOCKED is exactly LOCK_CYCLES cycles.
- The fail counter is 3 bits and saturates. It counts only consecutive failures and clears on success or at the end of lockout.
- DigitCount reads 0 in every state except PWD. It reads 4 during CHECK.

## Timing
- Reset (rst low, asynchronous): Phase=IDLE, LoggedIn=0, UserId=0, Failed=0, Locked=0, DigitCount=0, fail counter=0, timer=0, digit register=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- 4th enter sampled at edge N: Phase=CHECK after N; result visible after edge N+1.
  - Either LoggedIn=1, or Failed=1 for one cycle.
  - Locked=1 asserts on that same edge when lockout triggers.
- Locked is high for exactly LOCK_CYCLES cycles. The edge that ends it sets Phase=IDLE.
- Reset asserted mid-entry, mid-lockout or while logged in returns immediately to the reset values. Lockout does not survive reset.
- Enter pulses on consecutive cycles are each accepted; there is no minimum spacing.

## Test plan
- Reset, then: enter 1, then digits 1,1,1,1 → LoggedIn=1 and UserId=1 two cycles after the 4th enter; Failed stays 0. Then logout → LoggedIn=0 and Phase=0.
- User 0, digits 0,0,0,5 → one Failed pulse, Phase=IDLE, LoggedIn=0. Retry with 0,0,0,0 → LoggedIn=1.
- MAX_TRIES=3, LOCK_CYCLES=10: three wrong passwords for user 2.
  - Locked=1 for exactly 10 cycles and all buttons are ignored during that time.
  - Then Phase=0, and the correct 2,2,2,2 grants.
- Enter 3, digits 3,3, then clear → DigitCount=0. Then 3,3,3,3 → grant. Enter with Entry=9 in IDLE → stays IDLE.
- Simultaneous enter+clear in PWD with DigitCount=2 → DigitCount=0, no digit stored. Simultaneous logout+enter → IDLE.
- Assert rst mid-lockout and mid-PWD → all outputs return to reset values on that edge. A correct login afterwards succeeds.

Source files
------------

// File: rtl/access_control.sv
// access_control: login stage between the button decoder and the process controller.
// Collects a user ID (0..3) and a 4-digit hex password, checks it against the per-user
// password parameter and reports grant or deny. After MAX_TRIES consecutive failures,
// all input is locked out for LOCK_CYCLES clock cycles.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   ButtonVector  one-cycle pulses: [0] enter, [1] clear, [2] logout
//   Entry         digit value from the toggle switches
//   LoggedIn      high while a user is logged in
//   UserId        latched user ID, valid while LoggedIn
//   Failed        one-cycle pulse per failed password check
//   Locked        high during lockout
//   DigitCount    password digits entered so far (0..4)
//   Phase         state code: IDLE=0, PWD=1, CHECK=2, GRANTED=3, LOCKED=4
module access_control #(
  parameter logic [63:0] PASSWORDS   = 64'h0000_1111_2222_3333,
  parameter int unsigned MAX_TRIES   = 3,
  parameter logic [31:0] LOCK_CYCLES = 32'd250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ButtonVector,
  input  logic [3:0] Entry,
  output logic       LoggedIn,
  output logic [1:0] UserId,
  output logic       Failed,
  output logic       Locked,
  output logic [2:0] DigitCount,
  output logic [2:0] Phase
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PWD     = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_GRANTED = 3'd3;
  localparam logic [2:0] S_LOCKED  = 3'd4;

  logic [2:0]  r_phase,  w_phase_d;
  logic [1:0]  r_user,   w_user_d;
  logic [15:0] r_digits, w_digits_d;
  logic [2:0]  r_count,  w_count_d;
  logic [2:0]  r_fails,  w_fails_d;
  logic [31:0] r_timer,  w_timer_d;
  logic        r_failed, w_failed_d;
  logic        r_logged;
  logic        r_locked;

  // Only the highest-priority pulse acts: logout > clear > enter.
  logic w_logout, w_clear, w_enter;
  assign w_logout = ButtonVector[2];
  assign w_clear  = ButtonVector[1] & ~ButtonVector[2];
  assign w_enter  = ButtonVector[0] & ~ButtonVector[1] & ~ButtonVector[2];

  logic [15:0] w_expected;
  always_comb begin
    w_expected = PASSWORDS[63:48];
    case (r_user)
      2'd0:    w_expected = PASSWORDS[63:48];
      2'd1:    w_expected = PASSWORDS[47:32];
      2'd2:    w_expected = PASSWORDS[31:16];
      default: w_expected = PASSWORDS[15:0];
    endcase
  end

  // Saturating increment of the consecutive-failure count.
  logic [2:0] w_fails_inc;
  assign w_fails_inc = (r_fails == 3'd7) ? 3'd7 : r_fails + 3'd1;

  always_comb begin
    w_phase_d  = r_phase;
    w_user_d   = r_user;
    w_digits_d = r_digits;
    w_count_d  = r_count;
    w_fails_d  = r_fails;
    w_timer_d  = r_timer;
    w_failed_d = 1'b0;
    case (r_phase)
      S_IDLE: begin
        if (w_enter && (Entry <= 4'd3)) begin
          w_user_d   = Entry[1:0];
          w_digits_d = 16'd0;
          w_count_d  = 3'd0;
          w_phase_d  = S_PWD;
        end
      end
      S_PWD: begin
        if (w_logout) begin
          w_digits_d = 16'd0;
          w_count_d  = 3'd0;
          w_phase_d  = S_IDLE;
        end else if (w_clear) begin
          w_digits_d = 16'd0;
          w_count_d  = 3'd0;
        end else if (w_enter) begin
          w_digits_d = {r_digits[11:0], Entry};
          w_count_d  = r_count + 3'd1;
          if (r_count == 3'd3) w_phase_d = S_CHECK;
        end
      end
      S_CHECK: begin
        w_count_d = 3'd0;
        if (r_digits == w_expected) begin
          w_fails_d = 3'd0;
          w_phase_d = S_GRANTED;
        end else begin
          w_failed_d = 1'b1;
          w_fails_d  = w_fails_inc;
          if (w_fails_inc == 3'(MAX_TRIES)) begin
            // Loaded with N-1 so the exit edge (timer at 0) closes exactly N cycles.
            w_timer_d = LOCK_CYCLES - 32'd1;
            w_phase_d = S_LOCKED;
          end else begin
            w_phase_d = S_IDLE;
          end
        end
      end
      S_GRANTED: begin
        if (w_logout) w_phase_d = S_IDLE;
      end
      S_LOCKED: begin
        if (r_timer == 32'd0) begin
          w_fails_d = 3'd0;
          w_phase_d = S_IDLE;
        end else begin
          w_timer_d = r_timer - 32'd1;
        end
      end
      default: begin
        w_count_d = 3'd0;
        w_phase_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase  <= S_IDLE;
      r_user   <= 2'd0;
      r_digits <= 16'd0;
      r_count  <= 3'd0;
      r_fails  <= 3'd0;
      r_timer  <= 32'd0;
      r_failed <= 1'b0;
      r_logged <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_phase  <= w_phase_d;
      r_user   <= w_user_d;
      r_digits <= w_digits_d;
      r_count  <= w_count_d;
      r_fails  <= w_fails_d;
      r_timer  <= w_timer_d;
      r_failed <= w_failed_d;
      r_logged <= (w_phase_d == S_GRANTED);
      r_locked <= (w_phase_d == S_LOCKED);
    end
  end

  assign Phase      = r_phase;
  assign UserId     = r_user;
  assign DigitCount = r_count;
  assign Failed     = r_failed;
  assign LoggedIn   = r_logged;
  assign Locked     = r_locked;

endmodule

// File: tb/tb_access_control.sv
module tb_access_control;

  localparam logic [63:0] PW   = 64'h0000_1111_2222_3333;
  localparam int          TRY  = 3;
  localparam int          LOCK = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] bv  = 3'd0;
  logic [3:0] entry = 4'd0;
  logic       LoggedIn, Failed, Locked;
  logic [1:0] UserId;
  logic [2:0] DigitCount, Phase;

  int checks = 0;
  int errors = 0;

  access_control #(
    .PASSWORDS  (PW),
    .MAX_TRIES  (TRY),
    .LOCK_CYCLES(32'(LOCK))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ButtonVector(bv),
    .Entry       (entry),
    .LoggedIn    (LoggedIn),
    .UserId      (UserId),
    .Failed      (Failed),
    .Locked      (Locked),
    .DigitCount  (DigitCount),
    .Phase       (Phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode numbers are the Phase codes; digits kept as a queue.
  int m_phase = 0;
  int m_user = 0;
  int m_digits[$];
  int m_fails = 0;
  int m_left = 0;
  int m_failed = 0;

  function automatic int pw_of(input int u);
    return int'((PW >> (16 * (3 - u))) & 64'hFFFF);
  endfunction

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = 0; m_user = 0; m_digits.delete(); m_fails = 0; m_left = 0; m_failed = 0;
      end else begin
        bit e, c, lo;
        lo = bv[2];
        c  = bv[1] && !bv[2];
        e  = bv[0] && !bv[1] && !bv[2];
        m_failed = 0;
        case (m_phase)
          0: if (e && entry <= 3) begin
               m_user = int'(entry); m_digits.delete(); m_phase = 1;
             end
          1: if (lo) begin
               m_digits.delete(); m_phase = 0;
             end else if (c) begin
               m_digits.delete();
             end else if (e) begin
               m_digits.push_back(int'(entry));
               if (m_digits.size() == 4) m_phase = 2;
             end
          2: begin
               if (digits_value() == pw_of(m_user)) begin
                 m_fails = 0; m_phase = 3;
               end else begin
                 m_failed = 1;
                 m_fails = (m_fails + 1 > 7) ? 7 : m_fails + 1;
                 if (m_fails == TRY) begin
                   m_left = LOCK; m_phase = 4;
                 end else m_phase = 0;
               end
               m_digits.delete();
             end
          3: if (lo) m_phase = 0;
          default: begin
               m_left--;
               if (m_left == 0) begin
                 m_phase = 0; m_fails = 0;
               end
             end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("Phase", int'(Phase), m_phase);
      chk("LoggedIn", int'(LoggedIn), (m_phase == 3) ? 1 : 0);
      chk("Locked", int'(Locked), (m_phase == 4) ? 1 : 0);
      chk("Failed", int'(Failed), m_failed);
      chk("DigitCount", int'(DigitCount),
          (m_phase == 1 || m_phase == 2) ? m_digits.size() : 0);
      chk("UserId", int'(UserId), m_user);
    end
  end

  task automatic press(input logic [2:0] b, input logic [3:0] e);
    bv = b;
    entry = e;
    @(negedge clk);
    bv = 3'd0;
  endtask

  // Enters user then four digits; returns at the sample just after the result edge.
  task automatic attempt(input int u, input logic [15:0] p);
    logic [15:0] pp;
    pp = p;
    press(3'b001, 4'(u));
    press(3'b001, pp[15:12]);
    press(3'b001, pp[11:8]);
    press(3'b001, pp[7:4]);
    press(3'b001, pp[3:0]);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_Phase"}, int'(Phase), 0);
    chk({tag, "_LoggedIn"}, int'(LoggedIn), 0);
    chk({tag, "_Locked"}, int'(Locked), 0);
    chk({tag, "_Failed"}, int'(Failed), 0);
    chk({tag, "_DigitCount"}, int'(DigitCount), 0);
    chk({tag, "_UserId"}, int'(UserId), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    @(negedge clk);
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Correct login for user 1, result two cycles after the 4th enter.
    press(3'b001, 4'd1);
    press(3'b001, 4'd1); press(3'b001, 4'd1); press(3'b001, 4'd1); press(3'b001, 4'd1);
    chk("check_phase", int'(Phase), 2);
    chk("check_count", int'(DigitCount), 4);
    @(negedge clk);
    chk("grant_logged", int'(LoggedIn), 1);
    chk("grant_user", int'(UserId), 1);
    chk("grant_nofail", int'(Failed), 0);
    press(3'b100, 4'd0);
    chk("logout_logged", int'(LoggedIn), 0);
    chk("logout_phase", int'(Phase), 0);

    // Wrong then correct for user 0.
    attempt(0, 16'h0005);
    chk("wrong_failed", int'(Failed), 1);
    chk("wrong_phase", int'(Phase), 0);
    @(negedge clk);
    chk("wrong_pulse_end", int'(Failed), 0);
    attempt(0, 16'h0000);
    chk("retry_logged", int'(LoggedIn), 1);
    press(3'b100, 4'd0);

    // Lockout after three failures for user 2; buttons hammered during lock.
    attempt(2, 16'h1234); @(negedge clk);
    attempt(2, 16'h2223); @(negedge clk);
    attempt(2, 16'h0000);
    chk("lock_failed", int'(Failed), 1);
    chk("lock_locked", int'(Locked), 1);
    chk("lock_phase", int'(Phase), 4);
    cnt = 1;
    for (int i = 0; i < 50 && Locked; i++) begin
      press(3'($urandom_range(1, 7)), 4'($urandom_range(0, 3)));
      if (Locked) cnt++;
    end
    chk("lock_cycles", cnt, LOCK);
    chk("unlock_phase", int'(Phase), 0);
    attempt(2, 16'h2222);
    chk("unlock_grant", int'(LoggedIn), 1);
    press(3'b100, 4'd0);

    // Clear mid-entry, then good password.
    press(3'b001, 4'd3); press(3'b001, 4'd3); press(3'b001, 4'd3);
    chk("pre_clear_count", int'(DigitCount), 2);
    press(3'b010, 4'd0);
    chk("clear_count", int'(DigitCount), 0);
    chk("clear_phase", int'(Phase), 1);
    press(3'b001, 4'd3); press(3'b001, 4'd3); press(3'b001, 4'd3); press(3'b001, 4'd3);
    @(negedge clk);
    chk("clear_grant", int'(LoggedIn), 1);
    chk("clear_user", int'(UserId), 3);
    press(3'b100, 4'd0);
    press(3'b001, 4'd9);
    chk("bad_user_idle", int'(Phase), 0);

    // Coincident pulses.
    press(3'b001, 4'd0); press(3'b001, 4'd0); press(3'b001, 4'd0);
    press(3'b011, 4'd5);
    chk("enter_clear_count", int'(DigitCount), 0);
    chk("enter_clear_phase", int'(Phase), 1);
    press(3'b101, 4'd1);
    chk("logout_enter_phase", int'(Phase), 0);

    // Reset mid-lockout.
    attempt(1, 16'h0000); @(negedge clk);
    attempt(1, 16'h0000); @(negedge clk);
    attempt(1, 16'h0000);
    chk("lock2_locked", int'(Locked), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 reset_checks("rst_lock");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset mid-entry, then a correct login.
    press(3'b001, 4'd0); press(3'b001, 4'd0);
    #2 rst = 1'b0;
    #1 reset_checks("rst_pwd");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    attempt(3, 16'h3333);
    chk("post_rst_grant", int'(LoggedIn), 1);
    chk("post_rst_user", int'(UserId), 3);
    press(3'b100, 4'd0);

    // Randomized traffic, digits biased towards the selected user's password.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [2:0] b;
      logic [3:0] e;
      r = $urandom_range(0, 99);
      if (r < 55)      b = 3'b000;
      else if (r < 85) b = 3'b001;
      else if (r < 90) b = 3'b010;
      else if (r < 94) b = 3'b100;
      else             b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) e = 4'(m_user);
      else                           e = 4'($urandom_range(0, 15));
      bv = b;
      entry = e;
      @(negedge clk);
    end
    bv = 3'd0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
